// File: rtl/seg7_pkg.sv
// Shared types for the seg7 frame arbiter: frame layout, FSM states and requester ids.
package seg7_pkg;

  // [0] is digit 0 (bits 3:0) ... [3] is digit 3 (bits 15:12)
  typedef logic [3:0][3:0] frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    OPEN  = 2'd2
  } state_e;

  localparam logic REQ_HPS   = 1'b0;
  localparam logic REQ_LOCAL = 1'b1;

endpackage

// File: rtl/seg7_frame_arbiter_rr_grant2.sv
// Two-input round-robin grant: a lone valid wins, a tie goes to the requester
// that did not own the panel last.
module rr_grant2
  import seg7_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_owner == REQ_LOCAL) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/seg7_frame_arbiter.sv
// Time-shares the 4-digit 7-segment panel between the HPS and local frame sources
// with round-robin grant and a minimum dwell per frame. Optional: SEG7_ARB_PREEMPT_EN.
module seg7_frame_arbiter
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DWELL_W      = $clog2(DWELL_CYCLES + 1)
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_frame,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_frame,
  output logic        req1_ready,
  output logic [3:0]  disp_digit_0,
  output logic [3:0]  disp_digit_1,
  output logic [3:0]  disp_digit_2,
  output logic [3:0]  disp_digit_3,
  output logic        disp_owner,
  output logic        disp_blank
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               last_owner_q;
  logic               owner_q;
  logic               blank_q;
  frame_t             frame_q;

  logic [1:0]  grant;
  logic        open_win;
  logic        preempt;
  logic        acc0, acc1, accept;
  logic        acc_owner;
  logic [15:0] acc_frame;

  rr_grant2 u_grant (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner_q),
    .grant      (grant)
  );

  always_comb begin
    open_win = (state_q != DWELL);
    preempt  = 1'b0;
`ifdef SEG7_ARB_PREEMPT_EN
    // Only the HPS side may cut a local frame's dwell short.
    preempt  = (state_q == DWELL) && (owner_q == REQ_LOCAL) && req0_valid;
`endif
    // Readies are forced low while reset is held, independent of the grant.
    req0_ready = reset_reset_n & ((open_win & grant[0]) | preempt);
    req1_ready = reset_reset_n & open_win & grant[1];
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    accept     = acc0 | acc1;
    acc_owner  = acc1 ? REQ_LOCAL : REQ_HPS;
    acc_frame  = acc1 ? req1_frame : req0_frame;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = DWELL;
      cnt_d   = DWELL_LOAD;
    end else if (state_q == DWELL) begin
      if (cnt_q == '0) begin
        state_d = OPEN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= REQ_LOCAL;
      owner_q      <= REQ_HPS;
      blank_q      <= 1'b1;
      frame_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_owner_q <= acc_owner;
        owner_q      <= acc_owner;
        blank_q      <= 1'b0;
        frame_q      <= acc_frame;
      end
    end
  end

  assign disp_digit_0 = frame_q[0];
  assign disp_digit_1 = frame_q[1];
  assign disp_digit_2 = frame_q[2];
  assign disp_digit_3 = frame_q[3];
  assign disp_owner   = owner_q;
  assign disp_blank   = blank_q;

endmodule

// File: tb/tb_seg7_frame_arbiter.sv
// Scoreboard bench for seg7_frame_arbiter with DWELL_CYCLES=4; expected accepts are
// queued with their cycle, owner and frame and matched against observed handshakes.
module tb_seg7_frame_arbiter;

  localparam int D = 4;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_frame, req1_frame;
  logic        req0_ready, req1_ready;
  logic [3:0]  d0, d1, d2, d3;
  logic        owner, blank;

  seg7_frame_arbiter #(.DWELL_CYCLES(D)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req0_valid    (req0_valid),
    .req0_frame    (req0_frame),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_frame    (req1_frame),
    .req1_ready    (req1_ready),
    .disp_digit_0  (d0),
    .disp_digit_1  (d1),
    .disp_digit_2  (d2),
    .disp_digit_3  (d3),
    .disp_owner    (owner),
    .disp_blank    (blank)
  );

  typedef struct {
    int          cyc;
    logic        owner;
    logic [15:0] frame;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic        pend = 1'b0;
  logic        pend_owner;
  logic [15:0] pend_frame;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic o, input logic [15:0] f);
    exp_t e;
    e.cyc   = c;
    e.owner = o;
    e.frame = f;
    sb.push_back(e);
  endtask

  // Handshake monitor: pops the scoreboard on each accept, checks the panel one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      if (rst_n) begin
        check_eq("disp_frame", {16'h0, d3, d2, d1, d0}, {16'h0, pend_frame});
        check_eq("disp_owner", {31'h0, owner}, {31'h0, pend_owner});
        check_eq("disp_blank", {31'h0, blank}, 32'h0);
      end
    end
    if (rst_n && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
      if (req0_valid && req0_ready && req1_valid && req1_ready)
        check_eq("hs_both", 32'h1, 32'h0);
      if (sb.size() == 0) begin
        check_eq("hs_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("acc_cyc", 32'(cyc), 32'(e.cyc));
        check_eq("acc_owner", {31'h0, req1_valid && req1_ready}, {31'h0, e.owner});
        pend       = 1'b1;
        pend_owner = e.owner;
        pend_frame = e.frame;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_frame = '0;   req1_frame = '0;

    // Reset state, with a valid already pending
    repeat (3) tick();
    req0_valid = 1'b1;
    req0_frame = 16'h1234;
    #1;
    check_eq("rst_blank", {31'h0, blank}, 32'h1);
    check_eq("rst_digits", {16'h0, d3, d2, d1, d0}, 32'h0);
    check_eq("rst_readies", {30'h0, req1_ready, req0_ready}, 32'h0);
    tick();
    rst_n = 1'b1;
    push(cyc, 1'b0, 16'h1234);
    tick();
    req0_valid = 1'b0;
    check_eq("t1_digit0", {28'h0, d0}, 32'h4);
    check_eq("t1_digit3", {28'h0, d3}, 32'h1);

    // Frame persists in OPEN with no requesters
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        check_eq("persist_frame", {16'h0, d3, d2, d1, d0}, 32'h1234);
        check_eq("persist_readies", {30'h0, req1_ready, req0_ready}, 32'h0);
      end
      tick();
    end

    // Both valid from IDLE: alternation 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_frame = 16'hAAAA;
    req1_valid = 1'b1; req1_frame = 16'h5555;
    c = cyc;
    push(c,               1'b0, 16'hAAAA);
    push(c + (D + 1),     1'b1, 16'h5555);
    push(c + 2 * (D + 1), 1'b0, 16'hAAAA);
    push(c + 3 * (D + 1), 1'b1, 16'h5555);
    repeat (3 * (D + 1) + 1) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (D + 2) tick();

    // req1 arrives two cycles into req0's dwell
    c = cyc;
    req0_valid = 1'b1; req0_frame = 16'h0C0C;
    push(c, 1'b0, 16'h0C0C);
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_frame = 16'h9876;
    push(c + D + 1, 1'b1, 16'h9876);
    while (cyc < c + D + 1) begin
      @(negedge clk);
      check_eq("dwell_r1_low", {31'h0, req1_ready}, 32'h0);
      tick();
    end
    tick();
    req1_valid = 1'b0;
    repeat (D + 2) tick();

    // Reset mid-dwell blanks immediately; tie after release goes to req0
    c = cyc;
    req1_valid = 1'b1; req1_frame = 16'h7777;
    push(c, 1'b1, 16'h7777);
    tick();
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_blank", {31'h0, blank}, 32'h1);
    check_eq("arst_digits", {16'h0, d3, d2, d1, d0}, 32'h0);
    check_eq("arst_owner", {31'h0, owner}, 32'h0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_frame = 16'h1111;
    req1_valid = 1'b1; req1_frame = 16'h2222;
    push(cyc, 1'b0, 16'h1111);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (D + 2) tick();

    // req0 arrives during a local frame's dwell
    c = cyc;
    req1_valid = 1'b1; req1_frame = 16'hBEEF;
    push(c, 1'b1, 16'hBEEF);
    tick();
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_frame = 16'h00FF;
`ifdef SEG7_ARB_PREEMPT_EN
    t0 = c + 2;
`else
    t0 = c + D + 1;
`endif
    push(t0, 1'b0, 16'h00FF);
    while (cyc < t0) tick();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_frame = 16'h4444;
    push(t0 + D + 1, 1'b1, 16'h4444);
    while (cyc < t0 + D + 1) tick();
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();

    check_eq("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_frame_arbiter.md
# seg7_frame_arbiter

Time-shares the four-digit 7-segment panel between two frame sources: requester 0 (HPS-side seg7 PIO exports) and requester 1 (local status logic driven by buttons, mode and key_select). Each source offers a 16-bit frame (four hex nibbles) over a valid/ready handshake. The arbiter grants round-robin, holds each accepted frame for a minimum dwell time and drives the four nibbles into the existing display7 decoders in the top level.

## Interface
- DWELL_CYCLES, default 50_000_000: minimum cycles an accepted frame is held before another is accepted (1 s at 50 MHz); must be ≥1.
- DWELL_W, default $clog2(DWELL_CYCLES+1): dwell counter width (derived; do not override).

- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 (HPS) offers a frame.
- req0_frame  in  16  requester 0 frame; [3:0]=digit 0 … [15:12]=digit 3.
- req0_ready  out  1  requester 0 frame accepted this cycle when high with valid.
- req1_valid  in  1  requester 1 (local) offers a frame.
- req1_frame  in  16  requester 1 frame, same layout.
- req1_ready  out  1  requester 1 handshake.
- disp_digit_0 … disp_digit_3  out  4 each  nibble to display7 s0…s3.
- disp_owner  out  1  requester whose frame is shown.
- disp_blank  out  1  high until the first frame after reset is accepted.

## Operation
- FSM states: IDLE (no frame since reset), DWELL (frame held, counter running), OPEN (frame held, dwell expired).
- Grant: in IDLE/OPEN, one requester is granted combinationally. If only one valid, that one. If both valid, the one not equal to last_owner wins. reqN_ready = (state ∈ {IDLE, OPEN}) & grant[N]. A ready never rises for a requester whose valid is low.
- Accept (valid & ready at edge): frame → disp_digit_*, owner → disp_owner and last_owner, disp_blank ← 0, counter ← DWELL_CYCLES−1, state → DWELL.
- DWELL: counter decrements each cycle. Both readies stay low. At counter==0, go to OPEN next edge.
- OPEN: displayed frame persists indefinitely until the next accept. No timeout blanking.
- Requesters must hold valid and frame stable until ready; the arbiter does not buffer.
- Reset values: state IDLE, digits 0x0, disp_owner 0, disp_blank 1, last_owner 1 (so requester 0 wins the first tie), counter 0, both readies 0 while reset is asserted.
- Reset mid-DWELL: counter and frame are discarded immediately; the panel blanks.

## Timing
- Outputs are registered. A frame accepted at edge T is visible after T (one-cycle latency from handshake).
- Readies are low for exactly DWELL_CYCLES cycles after the accept edge. The earliest next accept is edge T+DWELL_CYCLES+1.
- With DWELL_CYCLES=1: accept at T, DWELL for one cycle, OPEN at T+1, next accept possible at T+2.
- Both valid continuously: alternation 0,1,0,1… with one accept every DWELL_CYCLES+1 cycles.

## Configuration
- SEG7_ARB_PREEMPT_EN defined: in DWELL, when disp_owner==1 and req0_valid is high, req0_ready is asserted. An accept then restarts the dwell with the requester-0 frame. Requester 1 can never preempt.
- Undefined: dwell is strictly enforced for both requesters as described above.

## Structure
- Package seg7_pkg: frame typedef (packed array of four 4-bit nibbles), state enum {IDLE, DWELL, OPEN}, requester index constants REQ_HPS=0 and REQ_LOCAL=1.
- One sub-module, rr_grant2: the two-input round-robin grant from valid[1:0] and last_owner. The dwell counter and FSM stay in the top body.
- Instantiated in top between the platform seg7 exports and the display7 instances.

## Test plan
(Run with DWELL_CYCLES=4.)
- Reset, no valid: disp_blank=1, digits 0, readies 0 → after req0 frame 0x1234 with valid: accept at first edge, digit_0=4, digit_3=1, blank=0, owner=0.
- Both valid from IDLE, frames 0xAAAA / 0x5555: first accept is req0. req1 is accepted exactly 5 cycles later, owner=1, digits 5. Alternation continues.
- req1 valid asserted 2 cycles into req0's dwell: req1_ready stays low until dwell ends, then accept. The frame is shown one cycle later.
- Reset asserted mid-DWELL: asynchronously blank=1, digits 0, state IDLE. After release, a tie goes to req0.
- No valid after an accept: frame persists in OPEN for 100 cycles unchanged, readies 0.
- SEG7_ARB_PREEMPT_EN defined, req1 frame in DWELL, req0 raises 0x00FF: accepted next edge, owner=0, dwell restarts (4 cycles). Without the macro, req0 waits for the full dwell.
